spi_xfer_ctrl: RTL and testbench
================================

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 I_clk  in  1  system clock (50 MHz), all logic on rising edge.
REQ-003 I_rst  in  1  asynchronous reset, active-high.
REQ-004 I_start  in  1  one-cycle transaction request, sampled only in IDLE.
REQ-005 I_cmd  in  8  command byte, captured at accepted start.
REQ-006 I_tx_len / I_rx_len  in  4 each  payload bytes to write / read (0-15), captured at accepted start.
REQ-007 I_tx_data  in  8  next payload byte, valid whenever O_tx_pop is high (first-word-fall-through source).
REQ-008 O_tx_pop  out  1  combinational, high for exactly the cycle I_tx_data is consumed.
REQ-009 O_rx_data  out  8 and O_rx_valid  out  1  received byte, valid for one cycle.
REQ-010 O_busy  out  1  high from the cycle after an accepted start until the return to IDLE.
REQ-011 O_done  out  1  one-cycle pulse at the end of a transaction.
REQ-012 O_eng_tx_en / O_eng_rx_en  out  1 each, O_eng_data  out  8  drive the byte engine's tx enable, rx enable and data input.
REQ-013 I_eng_tx_done / I_eng_rx_done  in  1 each, I_eng_rx_data  in  8  engine byte-done pulses and received byte.

Function
REQ-014 States SHALL be IDLE, CMD, TXD, RXD and GAP; all outputs except O_tx_pop are registered.
REQ-015 IDLE with I_start=1 SHALL:
  - latch I_cmd, I_tx_len and I_rx_len;
  - set O_eng_data=I_cmd and O_eng_tx_en=1;
  - enter CMD.
REQ-016 I_start SHALL be ignored in every state except IDLE; there is no queueing.
REQ-017 In CMD/TXD, I_eng_tx_done=1 with remaining tx count >0 SHALL:
  - assert O_tx_pop the same cycle;
  - load O_eng_data<=I_tx_data;
  - decrement the count;
  - go to or stay in TXD;
  - keep O_eng_tx_en high continuously, so chip select stays low between bytes.
REQ-018 In CMD/TXD, I_eng_tx_done=1 with tx count 0 and rx count >0 SHALL set O_eng_tx_en=0, O_eng_rx_en=1 and O_eng_data=0 in the same registered update, then enter RXD; there is no enable-low gap.
REQ-019 In CMD/TXD, I_eng_tx_done=1 with both counts 0 SHALL set O_eng_tx_en=0 and enter GAP.
REQ-020 In RXD, I_eng_rx_done=1 SHALL:
  - register O_rx_data<=I_eng_rx_data with O_rx_valid=1 on the next cycle;
  - decrement the rx count;
  - when the count reaches 0, set O_eng_rx_en=0 in that same update and enter GAP.
REQ-021 The enable deassert SHALL be registered exactly one cycle after the done pulse is seen; an earlier or later deassert produces a spurious SCK edge or an extra byte.
REQ-022 GAP SHALL:
  - last 2 cycles with both enables low (minimum chip-select-high time);
  - pulse O_done=1 in its first cycle;
  - then enter IDLE.
REQ-023 I_eng_tx_done in RXD/IDLE/GAP and I_eng_rx_done outside RXD SHALL be ignored.
REQ-024 O_eng_tx_en and O_eng_rx_en SHALL never be high in the same cycle.
REQ-025 A transaction SHALL transfer exactly 1+tx_len bytes out and rx_len bytes in; byte order is FIFO order, MSB-first per the engine.
REQ-026 Counters SHALL be 4 bits and never wrap: a decrement happens only when the count is >0.

Reset
REQ-027 I_rst=1 SHALL immediately (asynchronously) force state IDLE, counts 0, and all outputs 0: O_eng_tx_en, O_eng_rx_en, O_eng_data, O_rx_data, O_rx_valid, O_busy, O_done.
REQ-028 Reset mid-transaction SHALL abort with no O_done, and drop engine enables at once so chip select deasserts; the first start after release SHALL behave as a fresh transaction.

Verification
REQ-029 Command only: start, cmd=0x9F, tx_len=0, rx_len=0. Required: one byte 0x9F on MOSI; O_done 1 cycle; O_busy low 2 cycles after O_done; no pop, no rx_valid.
REQ-030 Write: cmd=0x02, tx_len=3, source 0x11,0x22,0x33. Required: MOSI carries 0x02,0x11,0x22,0x33 with chip select low throughout; exactly 3 O_tx_pop pulses; 32 SCK rising edges.
REQ-031 Read against an engine model returning 0xA5,0x5A: cmd=0x03, tx_len=1 (0x00), rx_len=2. Required: O_rx_valid twice with 0xA5 then 0x5A; no SCK edge after the last byte; rx_en deasserted 1 cycle after the final I_eng_rx_done.
REQ-032 Start pulses during busy: I_start at every cycle of a tx_len=2 transaction. Required: exactly one transaction and one O_done; the next start after IDLE is accepted.
REQ-033 Reset mid-read: assert I_rst during the 2nd rx byte of rx_len=4. Required: all outputs 0 in the same cycle, no O_done; a following cmd=0x05, rx_len=1 completes normally.
REQ-034 Max lengths: tx_len=15, rx_len=15. Required: 16 bytes out, 15 in, no counter wrap, single O_done.

Source files
------------

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side and byte-engine-side signals of the SPI transaction controller.
// The slave modport is the controller's view; master is the host/engine side.
interface spi_xfer_ctrl_if;
  logic       start;
  logic [7:0] cmd;
  logic [3:0] tx_len;
  logic [3:0] rx_len;
  logic [7:0] tx_data;
  logic       tx_pop;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       eng_tx_en;
  logic       eng_rx_en;
  logic [7:0] eng_data;
  logic       eng_tx_done;
  logic       eng_rx_done;
  logic [7:0] eng_rx_data;

  modport master (
    output start, cmd, tx_len, rx_len, tx_data, eng_tx_done, eng_rx_done, eng_rx_data,
    input  tx_pop, rx_data, rx_valid, busy, done, eng_tx_en, eng_rx_en, eng_data
  );

  modport slave (
    input  start, cmd, tx_len, rx_len, tx_data, eng_tx_done, eng_rx_done, eng_rx_data,
    output tx_pop, rx_data, rx_valid, busy, done, eng_tx_en, eng_rx_en, eng_data
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: one command byte, tx_len payload bytes out, rx_len bytes in,
// then a two-cycle chip-select-high gap. Feeds a byte-serial engine one byte at a time.
module spi_xfer_ctrl (
  input logic            clk,
  input logic            rst,
  spi_xfer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StCmd, StTxd, StRxd, StGap} state_e;

  state_e     state_q, state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic       gap_q, gap_d;
  logic       tx_en_q, tx_en_d;
  logic       rx_en_q, rx_en_d;
  logic [7:0] eng_data_q, eng_data_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tx_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_cnt_q   <= 4'd0;
      rx_cnt_q   <= 4'd0;
      gap_q      <= 1'b0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      eng_data_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      gap_q      <= gap_d;
      tx_en_q    <= tx_en_d;
      rx_en_q    <= rx_en_d;
      eng_data_q <= eng_data_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    gap_d      = gap_q;
    tx_en_d    = tx_en_q;
    rx_en_d    = rx_en_q;
    eng_data_d = eng_data_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    tx_pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          tx_cnt_d   = bus.tx_len;
          rx_cnt_d   = bus.rx_len;
          eng_data_d = bus.cmd;
          tx_en_d    = 1'b1;
          state_d    = StCmd;
        end
      end
      StCmd, StTxd: begin
        // tx_en stays high across payload bytes so chip select never blips.
        if (bus.eng_tx_done) begin
          if (tx_cnt_q != 4'd0) begin
            tx_pop     = 1'b1;
            eng_data_d = bus.tx_data;
            tx_cnt_d   = tx_cnt_q - 4'd1;
            state_d    = StTxd;
          end else if (rx_cnt_q != 4'd0) begin
            tx_en_d    = 1'b0;
            rx_en_d    = 1'b1;
            eng_data_d = 8'h00;
            state_d    = StRxd;
          end else begin
            tx_en_d = 1'b0;
            state_d = StGap;
          end
        end
      end
      StRxd: begin
        if (bus.eng_rx_done) begin
          rx_data_d  = bus.eng_rx_data;
          rx_valid_d = 1'b1;
          if (rx_cnt_q != 4'd0) begin
            rx_cnt_d = rx_cnt_q - 4'd1;
          end
          if (rx_cnt_q <= 4'd1) begin
            rx_en_d = 1'b0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        tx_en_d = 1'b0;
        rx_en_d = 1'b0;
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // done marks the first cycle of the chip-select-high gap.
    if (state_d == StGap && state_q != StGap) begin
      done_d = 1'b1;
      gap_d  = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  assign bus.tx_pop    = tx_pop;
  assign bus.eng_tx_en = tx_en_q;
  assign bus.eng_rx_en = rx_en_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifndef SYNTHESIS
  a_en_excl: assert property (@(posedge clk) disable iff (rst) !(tx_en_q && rx_en_q));
  a_pop_src: assert property (@(posedge clk) disable iff (rst) tx_pop |-> bus.eng_tx_done);
  a_gap_idle: assert property (@(posedge clk) disable iff (rst)
                               (state_q == StGap) |-> !(tx_en_q || rx_en_q));
`endif
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a cycle-level byte-engine model (8 SCK per byte,
// done pulse for one cycle, next byte starts the cycle after done).
module tb_spi_xfer_ctrl;
  logic clk = 1'b0;
  logic rst;

  spi_xfer_ctrl_if bus ();
  spi_xfer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus-owned data
  logic [7:0] tx_src  [0:255];
  logic [7:0] rx_resp [0:255];
  int tx_wr = 0;
  int rx_wr = 0;

  // Engine-owned
  logic [7:0] mosi_got [0:255];
  int mosi_n  = 0;
  int sck_cnt = 0;
  int bit_cnt = 0;
  int rx_rd   = 0;
  bit is_tx   = 1'b0;

  // Monitor-owned
  logic [7:0] rx_got [0:255];
  int rx_n        = 0;
  int pop_cnt     = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;
  int cs_fall_cnt = 0;
  int rxdata_bad  = 0;
  bit cs_prev     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_src[tx_wr] = b;
    tx_wr++;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_resp[rx_wr] = b;
    rx_wr++;
  endtask

  // Byte engine: acts 1 ns after each rising edge, so the controller sees its pulses next edge.
  initial begin
    bus.eng_tx_done = 1'b0;
    bus.eng_rx_done = 1'b0;
    bus.eng_rx_data = 8'h00;
    bus.tx_data     = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bit_cnt         = 0;
        bus.eng_tx_done = 1'b0;
        bus.eng_rx_done = 1'b0;
      end else if (bus.eng_tx_done || bus.eng_rx_done) begin
        bus.eng_tx_done = 1'b0;
        bus.eng_rx_done = 1'b0;
      end else if (bus.eng_tx_en || bus.eng_rx_en) begin
        if (bit_cnt == 0) begin
          is_tx = bus.eng_tx_en;
          if (is_tx && mosi_n < 256) begin
            mosi_got[mosi_n] = bus.eng_data;
            mosi_n++;
          end
        end
        sck_cnt++;
        if (bit_cnt == 7) begin
          bit_cnt = 0;
          if (is_tx) begin
            bus.eng_tx_done = 1'b1;
          end else begin
            bus.eng_rx_data = (rx_rd < 256) ? rx_resp[rx_rd] : 8'h00;
            rx_rd++;
            bus.eng_rx_done = 1'b1;
          end
        end else begin
          bit_cnt++;
        end
      end
      bus.tx_data = (pop_cnt < 256) ? tx_src[pop_cnt] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      cs_prev = 1'b0;
    end else begin
      if (bus.tx_pop) pop_cnt++;
      if (bus.rx_valid && rx_n < 256) begin
        rx_got[rx_n] = bus.rx_data;
        rx_n++;
      end
      if (bus.done) done_cnt++;
      if (bus.eng_tx_en && bus.eng_rx_en) overlap_cnt++;
      if (bus.eng_rx_en && bus.eng_data != 8'h00) rxdata_bad++;
      if (cs_prev && !(bus.eng_tx_en || bus.eng_rx_en)) cs_fall_cnt++;
      cs_prev = bus.eng_tx_en || bus.eng_rx_en;
    end
  end

  task automatic run_xfer(input logic [7:0] c, input int tl, input int rl, input bit hold);
    int b_pop, b_mosi, b_rx, b_done, b_sck, b_cs, cyc;
    logic [7:0] exp_b;
    b_pop  = pop_cnt;
    b_mosi = mosi_n;
    b_rx   = rx_n;
    b_done = done_cnt;
    b_sck  = sck_cnt;
    b_cs   = cs_fall_cnt;
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.cmd    = c;
    bus.tx_len = 4'(tl);
    bus.rx_len = 4'(rl);
    @(posedge clk);
    #1;
    if (!hold) begin
      // Scramble inputs to prove they were latched at start.
      bus.start  = 1'b0;
      bus.cmd    = 8'hEE;
      bus.tx_len = 4'hF;
      bus.rx_len = 4'hF;
    end
    @(negedge clk);
    check("acc_busy", 32'(bus.busy), 32'd1);
    check("acc_tx_en", 32'(bus.eng_tx_en), 32'd1);
    check("acc_data", 32'(bus.eng_data), 32'(c));
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(cyc < 2000), 32'd1);
    bus.start = 1'b0;
    check("gap1_busy", 32'(bus.busy), 32'd1);
    check("gap1_en", 32'({bus.eng_tx_en, bus.eng_rx_en}), 32'd0);
    @(negedge clk);
    check("gap2_done", 32'(bus.done), 32'd0);
    check("gap2_busy", 32'(bus.busy), 32'd1);
    check("gap2_en", 32'({bus.eng_tx_en, bus.eng_rx_en}), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("pop_count", pop_cnt - b_pop, tl);
    check("mosi_count", mosi_n - b_mosi, 1 + tl);
    check("rx_count", rx_n - b_rx, rl);
    check("done_count", done_cnt - b_done, 1);
    check("sck_edges", sck_cnt - b_sck, 8 * (1 + tl + rl));
    check("cs_deasserts", cs_fall_cnt - b_cs, 1);
    for (int i = 0; i < 1 + tl; i++) begin
      exp_b = (i == 0) ? c : tx_src[tx_wr - tl + i - 1];
      check("mosi_byte", 32'(mosi_got[b_mosi + i]), 32'(exp_b));
    end
    for (int i = 0; i < rl; i++) begin
      check("rx_byte", 32'(rx_got[b_rx + i]), 32'(rx_resp[rx_wr - rl + i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_en"}, 32'(bus.eng_tx_en), 32'd0);
    check({tag, "_rx_en"}, 32'(bus.eng_rx_en), 32'd0);
    check({tag, "_eng_data"}, 32'(bus.eng_data), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_tx_pop"}, 32'(bus.tx_pop), 32'd0);
  endtask

  initial begin
    int b_done, b_rx, cyc;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.cmd    = 8'h00;
    bus.tx_len = 4'h0;
    bus.rx_len = 4'h0;
    for (int i = 0; i < 256; i++) begin
      tx_src[i]  = 8'h00;
      rx_resp[i] = 8'h00;
    end

    @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b0;

    // Command only
    run_xfer(8'h9F, 0, 0, 1'b0);

    // Write: 0x02 then 0x11 0x22 0x33
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    run_xfer(8'h02, 3, 0, 1'b0);

    // Read: 0x03, dummy 0x00, two bytes in
    push_tx(8'h00);
    push_rx(8'hA5);
    push_rx(8'h5A);
    run_xfer(8'h03, 1, 2, 1'b0);

    // Start held high for the whole transaction, then a fresh start
    push_tx(8'h3C);
    push_tx(8'hC3);
    run_xfer(8'h12, 2, 0, 1'b1);
    run_xfer(8'h9F, 0, 0, 1'b0);

    // Reset during the second byte of a 4-byte read
    b_done = done_cnt;
    b_rx   = rx_n;
    push_rx(8'hA1);
    push_rx(8'hB2);
    push_rx(8'hC3);
    push_rx(8'hD4);
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.cmd    = 8'h0B;
    bus.tx_len = 4'd0;
    bus.rx_len = 4'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    while (rx_n == b_rx && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_rx1_seen", rx_n - b_rx, 1);
    repeat (3) @(negedge clk);
    check("rst_pre_rx_en", 32'(bus.eng_rx_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    check("rst_no_done", done_cnt - b_done, 0);
    rx_wr = rx_rd;

    push_rx(8'h77);
    run_xfer(8'h05, 0, 1, 1'b0);

    // Maximum lengths
    for (int i = 0; i < 15; i++) push_tx(8'h40 + 8'(i));
    for (int i = 0; i < 15; i++) push_rx(8'hC0 + 8'(i));
    run_xfer(8'h0B, 15, 15, 1'b0);

    check("en_overlap", overlap_cnt, 0);
    check("rx_phase_data", rxdata_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
